// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: arbitrates a fetch port and a load/store port onto a
// byte-wide memory, splitting each 32-bit word access into four byte cycles.
// Every output is registered; the comb block computes the next value of every
// register and the ff block only loads or resets them.
module mem_byte_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] adr0,
   output logic [31:0]      rdata0,
   output logic             ack0,
   input  logic             req1,
   input  logic             we1,
   input  logic [WIDTH-1:0] adr1,
   input  logic [31:0]      wdata1,
   input  logic [3:0]       be1,
   output logic [31:0]      rdata1,
   output logic             ack1,
   output logic             memread,
   output logic             memwrite,
   output logic [WIDTH-1:0] memadr,
   output logic [7:0]       memwritedata,
   input  logic [7:0]       memdata
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_FIN, S_WR, S_ACK} state_t;

   state_t           r_state,  w_state;
   logic [1:0]       r_cnt,    w_cnt;
   logic             r_port,   w_port;
   logic             r_last,   w_last;
   logic [WIDTH-3:0] r_base,   w_base;
   logic [31:0]      r_wdata,  w_wdata;
   logic [3:0]       r_be,     w_be;
   logic [23:0]      r_buf,    w_buf;     // bytes 0..2; byte 3 arrives in RD_FIN
   logic             r_memrd,  w_memrd;
   logic             r_memwr,  w_memwr;
   logic [WIDTH-1:0] r_memadr, w_memadr;
   logic [7:0]       r_memwd,  w_memwd;
   logic             r_ack0,   w_ack0;
   logic             r_ack1,   w_ack1;
   logic [31:0]      r_rdata0, w_rdata0;
   logic [31:0]      r_rdata1, w_rdata1;

   logic w_grant1;
   logic w_is_wr;
   logic w_unused;

   // Tie goes to the port that did not win last time.
   assign w_grant1 = req1 & (~req0 | ~r_last);
   assign w_is_wr  = w_grant1 & we1;
   assign w_unused = ^{adr0[1:0], adr1[1:0]};

   assign memread      = r_memrd;
   assign memwrite     = r_memwr;
   assign memadr       = r_memadr;
   assign memwritedata = r_memwd;
   assign ack0         = r_ack0;
   assign ack1         = r_ack1;
   assign rdata0       = r_rdata0;
   assign rdata1       = r_rdata1;

   // Next-state and next-output logic; strobes are presented one cycle ahead
   // so the registered outputs line up with the state they belong to.
   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_port   = r_port;
      w_last   = r_last;
      w_base   = r_base;
      w_wdata  = r_wdata;
      w_be     = r_be;
      w_buf    = r_buf;
      w_memrd  = 1'b0;
      w_memwr  = 1'b0;
      w_memadr = r_memadr;
      w_memwd  = r_memwd;
      w_ack0   = 1'b0;
      w_ack1   = 1'b0;
      w_rdata0 = r_rdata0;
      w_rdata1 = r_rdata1;
      unique case (r_state)
         S_IDLE: begin
            if (req0 | req1) begin
               w_port   = w_grant1;
               w_last   = w_grant1;
               w_base   = w_grant1 ? adr1[WIDTH-1:2] : adr0[WIDTH-1:2];
               w_wdata  = wdata1;
               w_be     = be1;
               w_cnt    = 2'd0;
               w_memadr = {w_base, 2'd0};
               if (w_is_wr) begin
                  w_state = S_WR;
                  w_memwr = be1[0];
                  w_memwd = wdata1[7:0];
               end else begin
                  w_state = S_RD;
                  w_memrd = 1'b1;
               end
            end
         end
         S_RD: begin
            // memdata lags the address by one cycle
            case (r_cnt)
               2'd1:    w_buf[7:0]   = memdata;
               2'd2:    w_buf[15:8]  = memdata;
               2'd3:    w_buf[23:16] = memdata;
               default: ;
            endcase
            w_cnt = r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
               w_state = S_RD_FIN;
            end else begin
               w_memrd  = 1'b1;
               w_memadr = {r_base, w_cnt};
            end
         end
         S_RD_FIN: begin
            w_state = S_ACK;
            if (r_port) begin
               w_ack1   = 1'b1;
               w_rdata1 = {memdata, r_buf};
            end else begin
               w_ack0   = 1'b1;
               w_rdata0 = {memdata, r_buf};
            end
         end
         S_WR: begin
            w_cnt = r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
               w_state = S_ACK;
               w_ack0  = ~r_port;
               w_ack1  = r_port;
            end else begin
               w_memadr = {r_base, w_cnt};
               w_memwr  = r_be[w_cnt];
               w_memwd  = r_wdata[{w_cnt, 3'b000} +: 8];
            end
         end
         S_ACK:   w_state = S_IDLE;
         default: w_state = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any transfer in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 2'd0;
         r_port   <= 1'b0;
         r_last   <= 1'b0;
         r_base   <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
         r_buf    <= '0;
         r_memrd  <= 1'b0;
         r_memwr  <= 1'b0;
         r_memadr <= '0;
         r_memwd  <= '0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_port   <= w_port;
         r_last   <= w_last;
         r_base   <= w_base;
         r_wdata  <= w_wdata;
         r_be     <= w_be;
         r_buf    <= w_buf;
         r_memrd  <= w_memrd;
         r_memwr  <= w_memwr;
         r_memadr <= w_memadr;
         r_memwd  <= w_memwd;
         r_ack0   <= w_ack0;
         r_ack1   <= w_ack1;
         r_rdata0 <= w_rdata0;
         r_rdata1 <= w_rdata1;
      end
   end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: byte memory model, directed vector table,
// multi-cycle corner sequences and random traffic against a word-level model.
module tb_mem_byte_sequencer;

   logic        clk = 1'b0;
   logic        reset, req0, req1, we1;
   logic [7:0]  adr0, adr1;
   logic [31:0] wdata1, rdata0, rdata1;
   logic [3:0]  be1;
   logic        ack0, ack1, memread, memwrite;
   logic [7:0]  memadr, memwritedata;
   logic [7:0]  memdata = 8'h00;

   always #5 clk = ~clk;

   mem_byte_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .adr0(adr0), .rdata0(rdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .adr1(adr1), .wdata1(wdata1), .be1(be1),
      .rdata1(rdata1), .ack1(ack1),
      .memread(memread), .memwrite(memwrite), .memadr(memadr),
      .memwritedata(memwritedata), .memdata(memdata)
   );

   // External byte memory: read data registered on the memread edge.
   logic [7:0] mem [256] = '{default: 8'h00};
   always @(posedge clk) begin
      if (memwrite) mem[memadr] <= memwritedata;
      if (memread)  memdata <= mem[memadr];
   end

   // Reference model: word view of memory, updated per completed transaction.
   logic [7:0] ref_mem [256] = '{default: 8'h00};

   function automatic logic [31:0] ref_read(input logic [7:0] adr);
      logic [7:0] b;
      b = {adr[7:2], 2'b00};
      return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
   endfunction

   task automatic ref_write(input logic [7:0] adr, input logic [31:0] wd, input logic [3:0] be);
      logic [7:0] b;
      b = {adr[7:2], 2'b00};
      for (int k = 0; k < 4; k++)
         if (be[k]) ref_mem[b + 8'(k)] = 8'((wd >> (8 * k)) & 32'hFF);
   endtask

   int errs = 0, checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // One transaction from an IDLE cycle; returns latency, strobe mask and a
   // count of protocol violations (wrong address/data, stray strobes/acks,
   // rdata changing when it must not). Ends in the IDLE cycle after the ack.
   task automatic txn(input bit port, input bit we, input logic [7:0] adr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rd, output int lat,
                      output logic [3:0] mask, output int bad);
      logic [31:0] p0, p1, sh;
      p0 = rdata0; p1 = rdata1;
      lat = -1; mask = 4'h0; bad = 0; rd = 32'h0;
      if (port) begin
         req0 = 1'b0; req1 = 1'b1; we1 = we; adr1 = adr; wdata1 = wd; be1 = be;
      end else begin
         req1 = 1'b0; req0 = 1'b1; adr0 = adr;
      end
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c <= 4) begin
            if ((memread | memwrite) && memadr !== {adr[7:2], 2'(c - 1)}) bad++;
            if (memread & we) bad++;
            if (memwrite & !we) bad++;
            if (memread | memwrite) mask[c - 1] = 1'b1;
            sh = wd >> (8 * (c - 1));
            if (memwrite && memwritedata !== sh[7:0]) bad++;
         end else if (memread | memwrite) bad++;
         if (port ? ack0 : ack1) bad++;
         if ((port ? rdata0 : rdata1) !== (port ? p0 : p1)) bad++;
         if (port ? ack1 : ack0) begin
            lat = c;
            rd = port ? rdata1 : rdata0;
            if (we && rd !== p1) bad++;
            break;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      if (ack0 | ack1) bad++;
   endtask

   task automatic run_chk(input string nm, input bit port, input bit we,
                          input logic [7:0] adr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_rd);
      logic [31:0] rd;
      logic [3:0]  mask;
      int          lat, bad;
      bit          w;
      w = port & we;
      txn(port, w, adr, wd, be, rd, lat, mask, bad);
      chk({nm, " latency"}, lat, w ? 32'd5 : 32'd6);
      if (!w) chk({nm, " rdata"}, rd, exp_rd);
      chk({nm, " strobes"}, {28'h0, mask}, w ? {28'h0, be} : 32'hF);
      chk({nm, " protocol"}, bad, 0);
      if (w) ref_write(adr, wd, be);
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [7:0]  adr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int q[$];
      int t1, t2, seen, ovl;
      logic [31:0] e;
      bit p, w;
      logic [7:0] a;

      tbl[0]  = '{1'b1, 1'b1, 8'h10, 32'hDDCCBBAA, 4'hF, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 8'h13, 32'h0,        4'h0, 32'hDDCCBBAA};
      tbl[2]  = '{1'b1, 1'b1, 8'h20, 32'h44332211, 4'hF, 32'h0};
      tbl[3]  = '{1'b1, 1'b0, 8'h20, 32'h0,        4'h0, 32'h44332211};
      tbl[4]  = '{1'b1, 1'b1, 8'h30, 32'hFFFFFFFF, 4'hF, 32'h0};
      tbl[5]  = '{1'b1, 1'b1, 8'h30, 32'h00AA00BB, 4'h5, 32'h0};
      tbl[6]  = '{1'b1, 1'b0, 8'h31, 32'h0,        4'h0, 32'hFFAAFFBB};
      tbl[7]  = '{1'b0, 1'b0, 8'h22, 32'h0,        4'h0, 32'h44332211};
      tbl[8]  = '{1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 4'h0, 32'h0};
      tbl[9]  = '{1'b0, 1'b0, 8'h20, 32'h0,        4'h0, 32'h44332211};
      tbl[10] = '{1'b1, 1'b1, 8'hFC, 32'h12345678, 4'hA, 32'h0};
      tbl[11] = '{1'b1, 1'b0, 8'hFF, 32'h0,        4'h0, 32'h12005600};

      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
      adr0 = 8'h0; adr1 = 8'h0; wdata1 = 32'h0; be1 = 4'h0;
      @(posedge clk); #1;
      chk("reset strobes", {30'h0, memread, memwrite}, 32'h0);
      chk("reset memadr", {24'h0, memadr}, 32'h0);
      chk("reset memwritedata", {24'h0, memwritedata}, 32'h0);
      chk("reset acks", {30'h0, ack0, ack1}, 32'h0);
      chk("reset rdata0", rdata0, 32'h0);
      chk("reset rdata1", rdata1, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // preload, then abort a port 0 read with reset in its cycle 3
      run_chk("preload", 1'b1, 1'b1, 8'h10, 32'hDDCCBBAA, 4'hF, 32'h0);
      req0 = 1'b1; adr0 = 8'h13;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1; req0 = 1'b0;
      @(posedge clk); #1;
      chk("abort memread", {31'h0, memread}, 32'h0);
      chk("abort ack0", {31'h0, ack0}, 32'h0);
      chk("abort rdata0", rdata0, 32'h0);
      reset = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ack0 | ack1 | memread | memwrite) seen++;
      end
      chk("abort quiet", seen, 0);
      chk("abort rdata0 held", rdata0, 32'h0);

      // directed vector table
      foreach (tbl[i])
         run_chk($sformatf("vec%0d", i), tbl[i].port, tbl[i].we, tbl[i].adr,
                 tbl[i].wd, tbl[i].be, tbl[i].exp);

      // tie after reset: port 1, port 0, port 1; acks never together
      do_reset();
      we1 = 1'b0; adr0 = 8'h10; adr1 = 8'h20;
      req0 = 1'b1; req1 = 1'b1;
      ovl = 0;
      for (int c = 0; c < 40 && q.size() < 3; c++) begin
         @(posedge clk); #1;
         if (ack0 & ack1) ovl++;
         if (ack1) q.push_back(1);
         else if (ack0) q.push_back(0);
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("tie ack count", q.size(), 3);
      while (q.size() < 3) q.push_back(-1);
      chk("tie first", q[0], 1);
      chk("tie second", q[1], 0);
      chk("tie third", q[2], 1);
      chk("tie overlap", ovl, 0);
      chk("tie rdata0", rdata0, 32'hDDCCBBAA);
      chk("tie rdata1", rdata1, 32'h44332211);

      // back-to-back held read on port 1: acks 7 cycles apart
      t1 = -1; t2 = -1;
      req1 = 1'b1; we1 = 1'b0; adr1 = 8'h20;
      for (int c = 0; c < 40 && t2 < 0; c++) begin
         @(posedge clk); #1;
         if (ack1) begin
            if (t1 < 0) t1 = c; else t2 = c;
         end
      end
      req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("b2b first ack", t1, 5);
      chk("b2b spacing", t2 - t1, 7);

      // random traffic against the word-level model
      for (int n = 0; n < 60; n++) begin
         p = 1'($urandom % 2);
         w = p & 1'($urandom % 2);
         a = 8'h40 + 8'($urandom % 32);
         e = ref_read(a);
         run_chk($sformatf("rnd%0d", n), p, w, a, $urandom, 4'($urandom), e);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- Sequencer and arbiter between two 32-bit word requesters and the byte-wide external memory.
- Port 0 is instruction fetch (read-only). Port 1 is data load/store with byte enables.
- The block grants one port, then issues four byte accesses on memread/memwrite/memadr/memwritedata.
- For reads it assembles the four bytes returned on memdata into a word and returns it with a one-cycle ack.

Parameters:
- WIDTH, 8, byte-address width of the external memory; bits [1:0] select the byte within a word.

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 word-read request
- adr0  in  WIDTH  port 0 byte address; bits [1:0] ignored
- rdata0  out  32  port 0 read word
- ack0  out  1  port 0 completion pulse
- req1  in  1  port 1 request
- we1  in  1  port 1: 1 = write, 0 = read
- adr1  in  WIDTH  port 1 byte address; bits [1:0] ignored
- wdata1  in  32  port 1 write word; byte k = bits [8k+7:8k]
- be1  in  4  port 1 write byte enables; ignored for reads
- rdata1  out  32  port 1 read word
- ack1  out  1  port 1 completion pulse
- memread  out  1  byte read strobe to memory
- memwrite  out  1  byte write strobe to memory
- memadr  out  WIDTH  byte address to memory
- memwritedata  out  8  write byte to memory
- memdata  in  8  memory read byte; registered in memory at the posedge where memread=1

Behaviour:
- Reset: state=IDLE; memread=0, memwrite=0, memadr=0, memwritedata=0; ack0=ack1=0; rdata0=rdata1=0; last_grant=0. These values apply from the edge after reset is sampled high.
- Reset mid-transfer: the transfer is aborted, no ack is issued, and partially assembled data is discarded.
- States: IDLE, RD, RD_FIN, WR, ACK. A 2-bit byte counter cnt is used.
- Request sampling: req is sampled only in IDLE.
- Arbitration:
  - If only one req is high, that port is granted.
  - If both are high, grant the port opposite last_grant.
  - last_grant resets to 0, so port 1 wins the first tie.
- On grant, latch port, base address {adr[WIDTH-1:2]}, we, wdata and be. Set cnt=0 and last_grant=granted port.
  - Go to WR if the granted port is 1 with we1=1; otherwise go to RD.
  - Requester inputs may change after the grant edge.
- RD, cnt=k:
  - memread=1, memadr={base,k}.
  - For k≥1, capture memdata into byte k-1 of the assembly buffer.
  - cnt increments; after k=3, go to RD_FIN.
- RD_FIN: memread=0; capture memdata into byte 3; go to ACK.
- WR, cnt=k:
  - memadr={base,k}, memwritedata=latched wdata byte k, memwrite=latched be[k].
  - Bytes whose enable is low are skipped, but the cycle is still spent.
  - After k=3, go to ACK.
  - be=0000 still completes and acks with no memory writes.
- ACK (single cycle):
  - ack of the granted port =1.
  - On a read, the granted port's rdata = assembled word, valid from this cycle.
  - rdata holds until that port's next read completes; writes never alter rdata.
  - The other port's rdata and ack are unchanged/0.
  - Next state is IDLE.
- Requester rule: drop req at the edge ending the ack cycle. A req still high in the following IDLE cycle is a new request.
- Latency, counting the IDLE cycle where req is sampled as cycle 0:
  - Read: ack in cycle 6.
  - Write: ack in cycle 5.
  - Idle gap of one cycle minimum between transfers.
- Outside RD/WR: memread=memwrite=0; memadr and memwritedata hold their last values.
- Byte order is little-endian: byte at address offset 0 maps to word bits [7:0].
- Address wrap: the counter only alters memadr[1:0]; the base never increments.

Test Plan:
- Port 0 read: preload word at byte addr 0x10 = 0xDDCCBBAA; req0=1, adr0=0x13 → memadr 0x10,0x11,0x12,0x13 with memread=1 in cycles 1-4; ack0=1 in cycle 6; rdata0=0xDDCCBBAA.
- Port 1 write: we1=1, adr1=0x20, wdata1=0x44332211, be1=1111 → memwrite in cycles 1-4 with bytes 11,22,33,44; ack1 in cycle 5; a subsequent read of 0x20 returns 0x44332211.
- Partial write: be1=0101 over word 0xFFFFFFFF, wdata1=0x00AA00BB → memwrite high only in cycles 1 and 3; word becomes 0xFFAAFFBB; rdata1 unchanged.
- Arbitration tie after reset: req0=req1=1 held → port 1 served first, then port 0, then port 1 (alternating); acks never overlap.
- Reset in RD at cycle 3 → memread=0 next cycle, no ack0, rdata0 stays 0; after reset, a fresh req0 completes normally in 6 cycles.
- Back-to-back: req1 read held continuously → acks 7 cycles apart (ack cycle plus one IDLE cycle before re-grant).
